// File: rtl/alu_issue_if.sv
// alu_issue_if: ID-side issue, ALU-side operand/result and WB-side result signals for alu_issue.
// Latency: none; this is a wire bundle.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; flush rides alongside.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rj_val;
    logic [31:0] in_rk_val;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    // Block side.
    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_rj_val, in_rk_val, alu_result, out_ready,
        output in_ready, alu_op, alu_src1, alu_src2,
        output out_valid, out_result, out_rd, out_we, out_pc, out_illegal
    );

    // ID / ALU / WB side.
    modport master (
        output flush, in_valid, in_inst, in_pc, in_rj_val, in_rk_val, alu_result, out_ready,
        input  in_ready, alu_op, alu_src1, alu_src2,
        input  out_valid, out_result, out_rd, out_we, out_pc, out_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes LA32R integer ops to one-hot ALU controls, selects operands, registers the ALU result for WB.
// Latency: 2 edges from acceptance to out_valid (S1 issue register, S2 result register), 1 instruction/cycle.
// Backpressure: S2 holds while out_valid && !out_ready; S1 holds behind it; in_ready drops only when S1 is full and S2 stalled.
module alu_issue (
    input  logic       clk,
    input  logic       resetn,
    alu_issue_if.slave bus
);

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    // Decode fields of the incoming instruction.
    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [31:0] imm_ui5;
    logic [31:0] imm_si12;
    logic [31:0] imm_ui12;
    logic [31:0] imm_u20;

    assign op17     = bus.in_inst[31:15];
    assign op10     = bus.in_inst[31:22];
    assign op7      = bus.in_inst[31:25];
    assign imm_ui5  = {27'b0, bus.in_inst[14:10]};
    assign imm_si12 = {{20{bus.in_inst[21]}}, bus.in_inst[21:10]};
    assign imm_ui12 = {20'b0, bus.in_inst[21:10]};
    assign imm_u20  = {bus.in_inst[24:5], 12'b0};

    // Per-format op lookup; a zero op means "not this format".
    logic [11:0] r3_op;
    logic [11:0] sh_op;
    logic [11:0] ri_op;
    logic        ri_sext;
    logic [11:0] u_op;
    logic        u_use_pc;

    // Match each opcode key against the supported encodings of its format.
    always_comb begin
        r3_op    = '0;
        sh_op    = '0;
        ri_op    = '0;
        ri_sext  = 1'b0;
        u_op     = '0;
        u_use_pc = 1'b0;
        case (op17)
            17'h00020: r3_op = OP_ADD;
            17'h00022: r3_op = OP_SUB;
            17'h00024: r3_op = OP_SLT;
            17'h00025: r3_op = OP_SLTU;
            17'h00028: r3_op = OP_NOR;
            17'h00029: r3_op = OP_AND;
            17'h0002A: r3_op = OP_OR;
            17'h0002B: r3_op = OP_XOR;
            17'h0002E: r3_op = OP_SLL;
            17'h0002F: r3_op = OP_SRL;
            17'h00030: r3_op = OP_SRA;
            17'h00081: sh_op = OP_SLL;
            17'h00089: sh_op = OP_SRL;
            17'h00091: sh_op = OP_SRA;
            default: ;
        endcase
        case (op10)
            10'h00A: begin ri_op = OP_ADD;  ri_sext = 1'b1; end
            10'h008: begin ri_op = OP_SLT;  ri_sext = 1'b1; end
            10'h009: begin ri_op = OP_SLTU; ri_sext = 1'b1; end
            10'h00D: ri_op = OP_AND;
            10'h00E: ri_op = OP_OR;
            10'h00F: ri_op = OP_XOR;
            default: ;
        endcase
        case (op7)
            7'h0A: u_op = OP_LUI;
            7'h0E: begin u_op = OP_ADD; u_use_pc = 1'b1; end
            default: ;
        endcase
    end

    logic [11:0] dec_op;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic        dec_illegal;

    // Pick the matching format and its operands; anything unmatched is illegal with op 0.
    always_comb begin
        dec_op      = '0;
        dec_src1    = '0;
        dec_src2    = '0;
        dec_illegal = 1'b1;
        if (r3_op != '0) begin
            dec_op      = r3_op;
            dec_src1    = bus.in_rj_val;
            dec_src2    = bus.in_rk_val;
            dec_illegal = 1'b0;
        end else if (sh_op != '0) begin
            dec_op      = sh_op;
            dec_src1    = bus.in_rj_val;
            dec_src2    = imm_ui5;
            dec_illegal = 1'b0;
        end else if (ri_op != '0) begin
            dec_op      = ri_op;
            dec_src1    = bus.in_rj_val;
            dec_src2    = ri_sext ? imm_si12 : imm_ui12;
            dec_illegal = 1'b0;
        end else if (u_op != '0) begin
            dec_op      = u_op;
            dec_src1    = u_use_pc ? bus.in_pc : 32'h0;
            dec_src2    = imm_u20;
            dec_illegal = 1'b0;
        end
    end

    // Pipeline state.
    logic        s1_valid;
    logic [11:0] s1_op;
    logic [31:0] s1_src1;
    logic [31:0] s1_src2;
    logic [4:0]  s1_rd;
    logic [31:0] s1_pc;
    logic        s1_illegal;

    logic        s2_valid;
    logic [31:0] s2_result;
    logic [4:0]  s2_rd;
    logic        s2_we;
    logic [31:0] s2_pc;
    logic        s2_illegal;

    logic s2_ready;
    logic in_ready;
    logic in_fire;
    logic s1_fire;

    assign s2_ready = !s2_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign in_fire  = bus.in_valid && in_ready;
    assign s1_fire  = s1_valid && s2_ready;

    // S1 issue register: flush wins over a same-cycle acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_src1    <= '0;
            s1_src2    <= '0;
            s1_rd      <= '0;
            s1_pc      <= '0;
            s1_illegal <= 1'b0;
        end else begin
            if (bus.flush) begin
                s1_valid <= 1'b0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_fire) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                s1_op      <= dec_op;
                s1_src1    <= dec_src1;
                s1_src2    <= dec_src2;
                s1_rd      <= bus.in_inst[4:0];
                s1_pc      <= bus.in_pc;
                s1_illegal <= dec_illegal;
            end
        end
    end

    // S2 result register: captures the ALU output as S1 advances; fields frozen while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_rd      <= '0;
            s2_we      <= 1'b0;
            s2_pc      <= '0;
            s2_illegal <= 1'b0;
        end else begin
            if (bus.flush) begin
                s2_valid <= 1'b0;
            end else if (s1_fire) begin
                s2_valid <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
            if (s1_fire) begin
                s2_result  <= s1_illegal ? 32'h0 : bus.alu_result;
                s2_rd      <= s1_rd;
                s2_we      <= !s1_illegal && (s1_rd != 5'd0);
                s2_pc      <= s1_pc;
                s2_illegal <= s1_illegal;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.alu_op      = s1_valid ? s1_op   : 12'h0;
    assign bus.alu_src1    = s1_valid ? s1_src1 : 32'h0;
    assign bus.alu_src2    = s1_valid ? s1_src2 : 32'h0;
    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_rd      = s2_rd;
    assign bus.out_we      = s2_we;
    assign bus.out_pc      = s2_pc;
    assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: drives alu_issue with LA32R instructions, models the ALU, scoreboards WB results.
// Latency: expects results 2 edges after acceptance when WB is ready.
// Backpressure: exercises out_ready stalls, flush and mid-stream reset.
module tb_alu_issue;
    logic clk;
    logic resetn;

    alu_issue_if bus ();

    alu_issue dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rj;
        logic [31:0] rk;
        logic [11:0] op;
        logic [31:0] res;
        logic [4:0]  rd;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t mix[15];
    logic [31:0] tb_alu_res;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU; an all-zero op yields garbage so forced-zero results are visible.
    always_comb begin
        tb_alu_res = 32'hDEADBEEF;
        case (bus.alu_op)
            12'h001: tb_alu_res = bus.alu_src1 + bus.alu_src2;
            12'h002: tb_alu_res = bus.alu_src1 - bus.alu_src2;
            12'h004: tb_alu_res = ($signed(bus.alu_src1) < $signed(bus.alu_src2)) ? 32'd1 : 32'd0;
            12'h008: tb_alu_res = (bus.alu_src1 < bus.alu_src2) ? 32'd1 : 32'd0;
            12'h010: tb_alu_res = bus.alu_src1 & bus.alu_src2;
            12'h020: tb_alu_res = ~(bus.alu_src1 | bus.alu_src2);
            12'h040: tb_alu_res = bus.alu_src1 | bus.alu_src2;
            12'h080: tb_alu_res = bus.alu_src1 ^ bus.alu_src2;
            12'h100: tb_alu_res = bus.alu_src1 << bus.alu_src2[4:0];
            12'h200: tb_alu_res = bus.alu_src1 >> bus.alu_src2[4:0];
            12'h400: tb_alu_res = $signed(bus.alu_src1) >>> bus.alu_src2[4:0];
            12'h800: tb_alu_res = bus.alu_src2;
            default: tb_alu_res = 32'hDEADBEEF;
        endcase
    end
    assign bus.alu_result = tb_alu_res;

    function automatic logic [31:0] f_3r(input logic [16:0] op, input logic [4:0] rk, input logic [4:0] rj, input logic [4:0] rd);
        return {op, rk, rj, rd};
    endfunction

    function automatic logic [31:0] f_ri12(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rj, input logic [4:0] rd);
        return {op, imm, rj, rd};
    endfunction

    function automatic logic [31:0] f_ri20(input logic [6:0] op, input logic [19:0] imm, input logic [4:0] rd);
        return {op, imm, rd};
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] rd, input logic we, input logic [31:0] pc, input logic ill);
        exp_t e;
        e.result  = r;
        e.rd      = rd;
        e.we      = we;
        e.pc      = pc;
        e.illegal = ill;
        return e;
    endfunction

    // Scoreboard: compare every WB handshake against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got result %h rd %0d with no expected entry", bus.out_result, bus.out_rd);
                end else begin
                    n_pass++;
                    mon_e = sb.pop_front();
                    n_total++;
                    if (bus.out_result !== mon_e.result) $display("FAIL sb_result: got %h expected %h", bus.out_result, mon_e.result);
                    else n_pass++;
                    n_total++;
                    if (bus.out_rd !== mon_e.rd) $display("FAIL sb_rd: got %0d expected %0d", bus.out_rd, mon_e.rd);
                    else n_pass++;
                    n_total++;
                    if (bus.out_we !== mon_e.we) $display("FAIL sb_we: got %b expected %b", bus.out_we, mon_e.we);
                    else n_pass++;
                    n_total++;
                    if (bus.out_pc !== mon_e.pc) $display("FAIL sb_pc: got %h expected %h", bus.out_pc, mon_e.pc);
                    else n_pass++;
                    n_total++;
                    if (bus.out_illegal !== mon_e.illegal) $display("FAIL sb_illegal: got %b expected %b", bus.out_illegal, mon_e.illegal);
                    else n_pass++;
                end
            end
        end
    end

    // Offer one instruction; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rj, input logic [31:0] rk, input exp_t e);
        bit acc;
        bit done;
        done = 1'b0;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.in_rj_val = rj;
        bus.in_rk_val = rk;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back(e);
                done = 1'b1;
            end
        end
        #1;
        n_total++;
        if (!done) $display("FAIL send_timeout: in_ready never seen for inst %h", inst);
        else n_pass++;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        n_total++;
        if (!done) $display("FAIL %s_drain: %0d results outstanding", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_inst = '0; bus.in_pc = '0; bus.in_rj_val = '0; bus.in_rk_val = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.alu_op !== 12'h0) $display("FAIL reset_alu_op: got %h expected 000", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src1 !== 32'h0) $display("FAIL reset_src1: got %h expected 0", bus.alu_src1); else n_pass++;
        n_total++; if (bus.out_result !== 32'h0) $display("FAIL reset_out_result: got %h expected 0", bus.out_result); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_release_valid: got %b expected 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_add();
        send(32'h00100823, 32'h1C000000, 32'd5, 32'd7, mk(32'd12, 5'd3, 1'b1, 32'h1C000000, 1'b0));
        n_total++; if (bus.alu_op !== 12'h001) $display("FAIL add_op: got %h expected 001", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src1 !== 32'd5) $display("FAIL add_src1: got %h expected 5", bus.alu_src1); else n_pass++;
        n_total++; if (bus.alu_src2 !== 32'd7) $display("FAIL add_src2: got %h expected 7", bus.alu_src2); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL add_early_valid: got %b expected 0", bus.out_valid); else n_pass++;
        idle();
        @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL add_latency: got out_valid %b expected 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.alu_op !== 12'h000) $display("FAIL add_op_one_cycle: got %h expected 000", bus.alu_op); else n_pass++;
        wait_drain("add");
    endtask

    task automatic test_srai();
        send(32'h004890A4, 32'h1C000004, 32'h80000000, 32'h12345678, mk(32'hF8000000, 5'd4, 1'b1, 32'h1C000004, 1'b0));
        n_total++; if (bus.alu_op !== 12'h400) $display("FAIL srai_op: got %h expected 400", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src2 !== 32'd4) $display("FAIL srai_src2: got %h expected 4", bus.alu_src2); else n_pass++;
        idle();
        wait_drain("srai");
    endtask

    task automatic test_sltui();
        send(f_ri12(10'h009, 12'hFFF, 5'd1, 5'd6), 32'h1C000008, 32'd5, 32'd0, mk(32'd1, 5'd6, 1'b1, 32'h1C000008, 1'b0));
        n_total++; if (bus.alu_op !== 12'h008) $display("FAIL sltui_op: got %h expected 008", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src2 !== 32'hFFFFFFFF) $display("FAIL sltui_src2: got %h expected ffffffff", bus.alu_src2); else n_pass++;
        idle();
        wait_drain("sltui");
    endtask

    task automatic test_pcaddu12i();
        send(f_ri20(7'h0E, 20'h00001, 5'd7), 32'h1C000000, 32'h0000AAAA, 32'h0, mk(32'h1C001000, 5'd7, 1'b1, 32'h1C000000, 1'b0));
        n_total++; if (bus.alu_op !== 12'h001) $display("FAIL pcadd_op: got %h expected 001", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src1 !== 32'h1C000000) $display("FAIL pcadd_src1: got %h expected 1c000000", bus.alu_src1); else n_pass++;
        n_total++; if (bus.alu_src2 !== 32'h00001000) $display("FAIL pcadd_src2: got %h expected 00001000", bus.alu_src2); else n_pass++;
        idle();
        wait_drain("pcadd");
    endtask

    task automatic test_mix();
        longint t0;
        longint t1;
        logic [31:0] pc;
        mix[0]  = '{f_3r(17'h00022, 5'd2, 5'd1, 5'd8),  32'd10,         32'd3,          12'h002, 32'd7,          5'd8};
        mix[1]  = '{f_ri20(7'h0A, 20'hABCDE, 5'd9),     32'h0000FFFF,   32'd1,          12'h800, 32'hABCDE000,   5'd9};
        mix[2]  = '{f_ri12(10'h00D, 12'hF0F, 5'd1, 5'd10), 32'hFFFFFFFF, 32'd0,         12'h010, 32'h00000F0F,   5'd10};
        mix[3]  = '{f_ri12(10'h00A, 12'hFFE, 5'd1, 5'd11), 32'd5,        32'd0,         12'h001, 32'd3,          5'd11};
        mix[4]  = '{f_3r(17'h00028, 5'd2, 5'd1, 5'd12), 32'hF0F0F0F0,   32'h0F0F0F00,   12'h020, 32'h0000000F,   5'd12};
        mix[5]  = '{f_3r(17'h0002E, 5'd2, 5'd1, 5'd0),  32'd1,          32'h21,         12'h100, 32'd2,          5'd0};
        mix[6]  = '{f_3r(17'h0002F, 5'd2, 5'd1, 5'd13), 32'h80000000,   32'd31,         12'h200, 32'd1,          5'd13};
        mix[7]  = '{f_3r(17'h00024, 5'd2, 5'd1, 5'd14), 32'hFFFFFFFF,   32'd1,          12'h004, 32'd1,          5'd14};
        mix[8]  = '{f_ri12(10'h00F, 12'h0FF, 5'd1, 5'd15), 32'h000000F0, 32'd0,         12'h080, 32'h0000000F,   5'd15};
        mix[9]  = '{f_3r(17'h0002A, 5'd2, 5'd1, 5'd16), 32'h00000100,   32'h00000001,   12'h040, 32'h00000101,   5'd16};
        mix[10] = '{f_3r(17'h00025, 5'd2, 5'd1, 5'd17), 32'hFFFFFFFF,   32'd1,          12'h008, 32'd0,          5'd17};
        mix[11] = '{f_3r(17'h00081, 5'd3, 5'd1, 5'd18), 32'd5,          32'h99,         12'h100, 32'd40,         5'd18};
        mix[12] = '{f_3r(17'h00089, 5'd4, 5'd1, 5'd19), 32'h000000F0,   32'h99,         12'h200, 32'h0000000F,   5'd19};
        mix[13] = '{f_ri12(10'h008, 12'h800, 5'd1, 5'd20), 32'hFFFFF000, 32'd0,         12'h004, 32'd1,          5'd20};
        mix[14] = '{f_ri12(10'h00E, 12'h800, 5'd1, 5'd21), 32'd1,        32'd0,         12'h040, 32'h00000801,   5'd21};
        t0 = $time;
        for (int i = 0; i < 15; i++) begin
            pc = 32'h1C000100 + 32'(i * 4);
            send(mix[i].inst, pc, mix[i].rj, mix[i].rk, mk(mix[i].res, mix[i].rd, mix[i].rd != 5'd0, pc, 1'b0));
            n_total++;
            if (bus.alu_op !== mix[i].op) $display("FAIL mix_op[%0d]: got %h expected %h", i, bus.alu_op, mix[i].op);
            else n_pass++;
        end
        t1 = $time;
        idle();
        n_total++;
        if (t1 - t0 != 150) $display("FAIL mix_throughput: took %0d time units expected 150", t1 - t0);
        else n_pass++;
        wait_drain("mix");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd20), 32'h1C000200, 32'd0, 32'd100, mk(32'd100, 5'd20, 1'b1, 32'h1C000200, 1'b0));
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd21), 32'h1C000204, 32'd1, 32'd100, mk(32'd101, 5'd21, 1'b1, 32'h1C000204, 1'b0));
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready_drop: got %b expected 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b expected 1", bus.out_valid); else n_pass++;
        fork
            send(f_3r(17'h00020, 5'd2, 5'd1, 5'd22), 32'h1C000208, 32'd2, 32'd100, mk(32'd102, 5'd22, 1'b1, 32'h1C000208, 1'b0));
            begin
                repeat (2) begin
                    @(negedge clk);
                    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
                    n_total++; if (bus.out_result !== 32'd100) $display("FAIL b2b_stall_hold: got %h expected 64", bus.out_result); else n_pass++;
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle();
        wait_drain("b2b");
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h1C000300, 32'd1, 32'd2, mk(32'd0, 5'd31, 1'b0, 32'h1C000300, 1'b1));
        n_total++; if (bus.alu_op !== 12'h000) $display("FAIL illegal_op: got %h expected 000", bus.alu_op); else n_pass++;
        send(f_3r(17'h00021, 5'd2, 5'd1, 5'd5), 32'h1C000304, 32'd1, 32'd2, mk(32'd0, 5'd5, 1'b0, 32'h1C000304, 1'b1));
        idle();
        wait_drain("illegal");
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd1), 32'h1C000400, 32'd1, 32'd1, mk(32'd2, 5'd1, 1'b1, 32'h1C000400, 1'b0));
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd2), 32'h1C000404, 32'd2, 32'd2, mk(32'd4, 5'd2, 1'b1, 32'h1C000404, 1'b0));
        idle();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_full: in_ready got %b expected 0", bus.in_ready); else n_pass++;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        sb.delete();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.alu_op !== 12'h000) $display("FAIL flush_alu_op: got %h expected 000", bus.alu_op); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
        bus.in_inst = f_3r(17'h00020, 5'd2, 5'd1, 5'd3);
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        idle();
        n_total++; if (bus.alu_op !== 12'h000) $display("FAIL flush_discard_s1: alu_op got %h expected 000", bus.alu_op); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_discard_s2: out_valid got %b expected 0", bus.out_valid); else n_pass++;
        bus.out_ready = 1'b1;
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd4), 32'h1C000408, 32'd3, 32'd4, mk(32'd7, 5'd4, 1'b1, 32'h1C000408, 1'b0));
        idle();
        wait_drain("flush");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd5), 32'h1C000500, 32'd10, 32'd1, mk(32'd11, 5'd5, 1'b1, 32'h1C000500, 1'b0));
        send(f_3r(17'h00020, 5'd2, 5'd1, 5'd6), 32'h1C000504, 32'd20, 32'd1, mk(32'd21, 5'd6, 1'b1, 32'h1C000504, 1'b0));
        idle();
        #2 resetn = 1'b0;
        #1;
        sb.delete();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.alu_op !== 12'h000) $display("FAIL rstmid_alu_op: got %h expected 000", bus.alu_op); else n_pass++;
        n_total++; if (bus.alu_src1 !== 32'h0) $display("FAIL rstmid_src1: got %h expected 0", bus.alu_src1); else n_pass++;
        n_total++; if (bus.out_result !== 32'h0) $display("FAIL rstmid_result: got %h expected 0", bus.out_result); else n_pass++;
        n_total++; if (bus.out_rd !== 5'd0) $display("FAIL rstmid_rd: got %0d expected 0", bus.out_rd); else n_pass++;
        n_total++; if (bus.out_we !== 1'b0) $display("FAIL rstmid_we: got %b expected 0", bus.out_we); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL rstmid_pc: got %h expected 0", bus.out_pc); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_release: out_valid got %b expected 0", bus.out_valid); else n_pass++;
        send(f_3r(17'h00022, 5'd2, 5'd1, 5'd7), 32'h1C000508, 32'd50, 32'd8, mk(32'd42, 5'd7, 1'b1, 32'h1C000508, 1'b0));
        idle();
        wait_drain("rstmid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_sltui();
        test_pcaddu12i();
        test_mix();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
